data_memory_param: RTL and testbench

Parametrised, byte-writable, synchronous-read data memory for the RISC core's memory stage, replacing the fixed 64×16 data memory. It adds three things:
- a hardware clear sequencer that zeroes every word after reset or on request;
- a registered read with a valid strobe;
- defined same-cycle read/write and out-of-range behaviour.

It sits between the datapath's load/store unit and the writeback mux.

---
 rtl/data_memory_param_pkg.sv | 18 +
 rtl/data_memory_param_if.sv | 32 +++
 rtl/data_memory_param_clear_ctrl.sv | 51 +++++
 rtl/data_memory_param.sv | 132 +++++++++++++
 tb/tb_data_memory_param.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_param_pkg.sv
// Shared types and helpers for the byte-writable data memory.
// Build option: PARITY_EN adds per-byte even parity storage and checking.
package dmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int byte_cnt(input int dw);
    return dw / 8;
  endfunction

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Load/store port bundle between the memory stage and the data memory.
// Build option: PARITY_EN (parity_err is only meaningful when defined).
interface data_memory_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_W/8-1:0]   byte_en;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     data_in;
  logic                  clr_req;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  addr_err;
  logic                  parity_err;

  modport master (
    output wr_en, rd_en, byte_en,
    output mem_address, data_in, clr_req,
    input  data_out, rd_valid, busy,
    input  addr_err, parity_err
  );

  modport slave (
    input  wr_en, rd_en, byte_en,
    input  mem_address, data_in, clr_req,
    output data_out, rd_valid, busy,
    output addr_err, parity_err
  );
endinterface

// File: rtl/data_memory_param_clear_ctrl.sv
// Clear sequencer: walks every word once after reset or clr_req.
// Build option: PARITY_EN has no effect here.
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      busy     <= 1'b1;
      clr_addr <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
      endcase
    end
  end

  assign clr_we = busy;

endmodule

// File: rtl/data_memory_param.sv
// Byte-writable, registered-read data memory with hardware clear.
// Build option: PARITY_EN stores one even-parity bit per byte.
module data_memory_param
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input logic               clk,
  input logic               rst,
  data_memory_param_if.slave bus
);

  localparam int NB = byte_cnt(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  dmem_clear_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  logic              in_range;
  logic              acc;
  logic [NB-1:0]     wr_be;
  logic              user_we;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] new_word;

  assign in_range = {1'b0, bus.mem_address}
                  < (ADDR_W+1)'(DEPTH);
  assign acc      = !busy && in_range;
  assign wr_be    = (bus.wr_en && acc)
                  ? bus.byte_en : '0;
  assign user_we  = |wr_be;
  assign old_word = in_range
                  ? mem[bus.mem_address] : '0;

  // Merged word doubles as write-first read data.
  always_comb begin
    new_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i])
        new_word[8*i +: 8] = bus.data_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (user_we)
      mem[bus.mem_address] <= new_word;
  end

  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= !busy && bus.rd_en;
      addr_err <= !busy && !in_range
                && (bus.wr_en || bus.rd_en);
      if (!busy && bus.rd_en)
        data_out <= in_range ? new_word : '0;
    end
  end

`ifdef PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] old_par;
  logic [NB-1:0] new_par;
  logic [NB-1:0] mism;
  logic          parity_err;

  assign old_par = in_range
                 ? par[bus.mem_address] : '0;

  // Freshly written bytes cannot mismatch.
  always_comb begin
    new_par = old_par;
    mism    = '0;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i])
        new_par[i] = even_par(bus.data_in[8*i +: 8]);
      else
        mism[i] = old_par[i]
                ^ even_par(old_word[8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we)
      par[clr_addr] <= '0;
    else if (user_we)
      par[bus.mem_address] <= new_par;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_err <= 1'b0;
    else
      parity_err <= acc && bus.rd_en && (|mism);
  end

  assign bus.parity_err = parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data_out = data_out;
  assign bus.rd_valid = rd_valid;
  assign bus.addr_err = addr_err;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param: 64-word and 48-word builds.
// Build option: PARITY_EN (parity_err expected 0 in every case).
module tb_data_memory_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  data_memory_param_if #(.DATA_W(16), .ADDR_W(6)) b1 ();
  data_memory_param_if #(.DATA_W(16), .ADDR_W(6)) b2 ();

  data_memory_param #(
    .DATA_W(16), .ADDR_W(6), .DEPTH(64)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  data_memory_param #(
    .DATA_W(16), .ADDR_W(6), .DEPTH(48)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  be;
    logic [5:0]  a;
    logic [15:0] d;
    logic        ev;
    logic [15:0] eo;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mk(
    input logic wr, input logic rd,
    input logic [1:0] be, input logic [5:0] a,
    input logic [15:0] d, input logic ev,
    input logic [15:0] eo
  );
    vec_t v;
    v.wr = wr; v.rd = rd; v.be = be; v.a = a;
    v.d = d; v.ev = ev; v.eo = eo;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic cyc1(
    input logic wr, input logic rd,
    input logic [1:0] be, input logic [5:0] a,
    input logic [15:0] d
  );
    b1.wr_en = wr; b1.rd_en = rd; b1.byte_en = be;
    b1.mem_address = a; b1.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic cyc2(
    input logic wr, input logic rd,
    input logic [1:0] be, input logic [5:0] a,
    input logic [15:0] d
  );
    b2.wr_en = wr; b2.rd_en = rd; b2.byte_en = be;
    b2.mem_address = a; b2.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic count_busy1(output int n);
    n = 0;
    while (b1.busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, n1, n2, vis;
    b1.wr_en = 0; b1.rd_en = 0; b1.byte_en = 0;
    b1.mem_address = 0; b1.data_in = 0; b1.clr_req = 0;
    b2.wr_en = 0; b2.rd_en = 0; b2.byte_en = 0;
    b2.mem_address = 0; b2.data_in = 0; b2.clr_req = 0;

    tv.push_back(mk(0,1,2'b00, 0,16'h0000,1,16'h0000));
    tv.push_back(mk(0,1,2'b00,31,16'h0000,1,16'h0000));
    tv.push_back(mk(0,1,2'b00,63,16'h0000,1,16'h0000));
    tv.push_back(mk(1,0,2'b11, 5,16'hBEEF,0,16'h0000));
    tv.push_back(mk(1,0,2'b01, 5,16'h0012,0,16'h0000));
    tv.push_back(mk(0,1,2'b00, 5,16'h0000,1,16'hBE12));
    tv.push_back(mk(1,1,2'b11, 9,16'h1234,1,16'h1234));
    tv.push_back(mk(0,0,2'b00, 0,16'h0000,0,16'h1234));
    tv.push_back(mk(1,0,2'b10, 5,16'h7700,0,16'h1234));
    tv.push_back(mk(0,1,2'b00, 5,16'h0000,1,16'h7712));
    tv.push_back(mk(1,1,2'b00, 9,16'hFFFF,1,16'h1234));
    tv.push_back(mk(1,1,2'b10, 9,16'hABCD,1,16'hAB34));
    tv.push_back(mk(1,0,2'b11,10,16'h5555,0,16'hAB34));
    tv.push_back(mk(0,1,2'b00,10,16'h0000,1,16'h5555));
    tv.push_back(mk(1,0,2'b11, 7,16'h1111,0,16'h5555));
    tv.push_back(mk(0,1,2'b00, 5,16'h0000,1,16'h7712));
    tv.push_back(mk(1,0,2'b11,20,16'h00FF,0,16'h7712));
    tv.push_back(mk(0,1,2'b00,20,16'h0000,1,16'h00FF));
    tv.push_back(mk(1,1,2'b11,21,16'h0101,1,16'h0101));
    tv.push_back(mk(0,1,2'b00, 7,16'h0000,1,16'h1111));
    tv.push_back(mk(0,1,2'b00,21,16'h0000,1,16'h0101));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst dout", b1.data_out, 0);
    chk("rst valid", b1.rd_valid, 0);
    chk("rst busy", b1.busy, 1);
    chk("rst aerr", b1.addr_err, 0);
    chk("rst perr", b1.parity_err, 0);
    chk("rst busy2", b2.busy, 1);
    rst = 0;

    // Initial clear length for both depths
    n = 0; n1 = 0; n2 = 0;
    while ((b1.busy || b2.busy) && n < 200) begin
      if (b1.busy) n1++;
      if (b2.busy) n2++;
      n++;
      @(posedge clk); #1;
    end
    chk("clear len 64", n1, 64);
    chk("clear len 48", n2, 48);

    // Table vectors
    for (int i = 0; i < tv.size(); i++) begin
      cyc1(tv[i].wr, tv[i].rd, tv[i].be,
           tv[i].a, tv[i].d);
      chk($sformatf("v%0d valid", i),
          b1.rd_valid, tv[i].ev);
      chk($sformatf("v%0d dout", i),
          b1.data_out, tv[i].eo);
      chk($sformatf("v%0d aerr", i),
          b1.addr_err, 0);
      chk($sformatf("v%0d perr", i),
          b1.parity_err, 0);
    end
    cyc1(0, 0, 0, 0, 0);

    // clr_req with reads during busy and a re-request
    b1.clr_req = 1;
    cyc1(0, 0, 0, 0, 0);
    b1.clr_req = 0;
    chk("clr busy rise", b1.busy, 1);
    n = 1; vis = 0;
    while (b1.busy && n < 200) begin
      b1.rd_en = 1;
      b1.mem_address = 10;
      b1.clr_req = (n == 30);
      @(posedge clk); #1;
      if (b1.rd_valid) vis++;
      if (b1.busy) n++;
    end
    b1.rd_en = 0; b1.clr_req = 0;
    chk("clr len", n, 64);
    chk("clr no valid", vis, 0);
    chk("clr dout hold", b1.data_out, 16'h0101);
    cyc1(0, 1, 0, 10, 0);
    chk("clr rd10 valid", b1.rd_valid, 1);
    chk("clr rd10 dout", b1.data_out, 0);

    // Reset during an in-flight read
    cyc1(1, 0, 2'b11, 3, 16'h4242);
    cyc1(0, 1, 0, 3, 0);
    chk("pre rd3", b1.data_out, 16'h4242);
    b1.rd_en = 1; b1.mem_address = 3;
    #2 rst = 1;
    @(posedge clk); #1;
    b1.rd_en = 0;
    chk("rstacc valid", b1.rd_valid, 0);
    chk("rstacc dout", b1.data_out, 0);
    chk("rstacc busy", b1.busy, 1);
    rst = 0;
    count_busy1(n);
    chk("rstacc clr len", n, 64);
    cyc1(0, 1, 0, 3, 0);
    chk("rstacc rd3", b1.data_out, 0);

    // Reset at clear counter 20
    b1.clr_req = 1;
    cyc1(0, 0, 0, 0, 0);
    b1.clr_req = 0;
    repeat (20) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid rst busy", b1.busy, 1);
    @(posedge clk); #1;
    rst = 0;
    count_busy1(n);
    chk("mid rst clr len", n, 64);

    // DEPTH=48 out-of-range behaviour
    cyc2(1, 0, 2'b11, 47, 16'h1357);
    chk("d48 wr47 aerr", b2.addr_err, 0);
    cyc2(0, 1, 0, 47, 0);
    chk("d48 rd47", b2.data_out, 16'h1357);
    cyc2(1, 0, 2'b11, 50, 16'hAAAA);
    chk("d48 wr50 aerr", b2.addr_err, 1);
    chk("d48 wr50 valid", b2.rd_valid, 0);
    cyc2(0, 0, 0, 0, 0);
    chk("d48 aerr pulse", b2.addr_err, 0);
    cyc2(0, 1, 0, 50, 0);
    chk("d48 rd50 aerr", b2.addr_err, 1);
    chk("d48 rd50 valid", b2.rd_valid, 1);
    chk("d48 rd50 dout", b2.data_out, 0);
    chk("d48 rd50 perr", b2.parity_err, 0);
    cyc2(0, 1, 0, 2, 0);
    chk("d48 rd2 nowrap", b2.data_out, 0);
    chk("d48 rd2 aerr", b2.addr_err, 0);
    cyc2(0, 1, 0, 47, 0);
    chk("d48 rd47 kept", b2.data_out, 16'h1357);
    cyc2(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
